// File: rtl/alu_share_pkg.sv
// alu_share_pkg
// Shared types and constants for the shared-ALU arbiter slice.
//   alu_func_e  : 2-bit ALU function code carried with each request
//   arb_state_e : sequencing states of the arbiter FSM
//   RES_W       : width of the ALU result / response data
package alu_share_pkg;

  typedef enum logic [1:0] {
    FN_ADD = 2'd0,
    FN_OR  = 2'd1,
    FN_AND = 2'd2,
    FN_CAT = 2'd3
  } alu_func_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } arb_state_e;

  localparam int RES_W = 8;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin priority selector. The winner is the first set
// bit of valid found by searching upward from rr_ptr, wrapping modulo N.
// Ports:
//   valid     in  N      request vector
//   rr_ptr    in  IDX_W  highest-priority index this cycle
//   grant     out N      one-hot winner (all zero when nothing is valid)
//   grant_idx out IDX_W  encoded winner (0 when nothing is valid)
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  // Walk offsets from farthest to nearest so the nearest valid index from
  // rr_ptr is the last one written and therefore wins.
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (valid[IDX_W'(j)]) begin
        grant              = '0;
        grant[IDX_W'(j)]   = 1'b1;
        grant_idx          = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one 4-bit ALU between NUM_REQ requesters. A round-robin arbiter
// accepts one request at a time, the FSM evaluates the ALU on the latched
// operands and returns the 8-bit result tagged with the requester ID on a
// single response channel with backpressure.
// Optional build macro ALU_SHARE_STATS_EN adds per-requester saturating
// grant counters (grant_count) with a synchronous clear (stats_clr).
// Ports:
//   Clock        in   system clock, rising edge
//   Reset_b      in   asynchronous active-low reset
//   req_valid    in   [NUM_REQ]     per-requester valid
//   req_ready    out  [NUM_REQ]     per-requester accept, at most one high
//   req_a/req_b  in   [NUM_REQ*4]   operands, requester i at [4i+3:4i]
//   req_func     in   [NUM_REQ*2]   function code, requester i at [2i+1:2i]
//   rsp_valid    out  result available
//   rsp_ready    in   consumer accepts result
//   rsp_id       out  [ID_W]  owner of the result
//   rsp_data     out  [8]     ALU result
//   busy         out  high whenever the FSM is not idle
//   grant_count  out  [NUM_REQ*8] (ALU_SHARE_STATS_EN only)
//   stats_clr    in   (ALU_SHARE_STATS_EN only)
//
// state  | meaning
// S_IDLE | waiting for a request; req_ready follows the round-robin winner
// S_EXEC | operands latched; ALU result registered into rsp_data
// S_RESP | rsp_valid held until rsp_ready; then pointer advances past owner
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 Clock,
  input  logic                 Reset_b,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*4-1:0] req_a,
  input  logic [NUM_REQ*4-1:0] req_b,
  input  logic [NUM_REQ*2-1:0] req_func,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [RES_W-1:0]     rsp_data,
  output logic                 busy
`ifdef ALU_SHARE_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [NUM_REQ*8-1:0] grant_count
`endif
);

  arb_state_e         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [3:0]         lat_a;
  logic [3:0]         lat_b;
  alu_func_e          lat_func;
  logic [ID_W-1:0]    lat_id;
  logic [RES_W-1:0]   alu_res;
  logic [4:0]         sum;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;

  logic [3:0]         a_arr [NUM_REQ];
  logic [3:0]         b_arr [NUM_REQ];
  logic [1:0]         f_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[4*i +: 4];
    assign b_arr[i] = req_b[4*i +: 4];
    assign f_arr[i] = req_func[2*i +: 2];
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_pick (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  // Ready is combinational so the transfer completes in the arbitration
  // cycle. Gated by reset so no requester sees an accept while held in reset.
  assign req_ready = (state == S_IDLE && Reset_b) ? pick_grant : '0;

  always_comb begin
    sum     = {1'b0, lat_a} + {1'b0, lat_b};
    alu_res = '0;
    case (lat_func)
      FN_ADD:  alu_res = {3'b000, sum};
      FN_OR:   alu_res = {7'b0, |{lat_a, lat_b}};
      FN_AND:  alu_res = {7'b0, &{lat_a, lat_b}};
      FN_CAT:  alu_res = {lat_a, lat_b};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      lat_a     <= '0;
      lat_b     <= '0;
      lat_func  <= FN_ADD;
      lat_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            lat_a    <= a_arr[pick_idx];
            lat_b    <= b_arr[pick_idx];
            lat_func <= alu_func_e'(f_arr[pick_idx]);
            lat_id   <= pick_idx;
            state    <= S_EXEC;
            busy     <= 1'b1;
          end
        end
        S_EXEC: begin
          rsp_data  <= alu_res;
          rsp_id    <= lat_id;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (lat_id == ID_W'(NUM_REQ - 1)) ? '0 : lat_id + 1'b1;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SHARE_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    logic [7:0] cnt;
    // Clear has priority over a same-cycle grant; counter sticks at 8'hFF.
    always_ff @(posedge Clock or negedge Reset_b) begin
      if (!Reset_b) begin
        cnt <= '0;
      end else if (stats_clr) begin
        cnt <= '0;
      end else if (req_valid[i] && req_ready[i] && cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
    end
    assign grant_count[8*i +: 8] = cnt;
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int N  = 2;
  localparam int IW = 1;

  logic           Clock = 1'b0;
  logic           Reset_b;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*4-1:0] req_a;
  logic [N*4-1:0] req_b;
  logic [N*2-1:0] req_func;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [7:0]     rsp_data;
  logic           busy;
`ifdef ALU_SHARE_STATS_EN
  logic           stats_clr;
  logic [N*8-1:0] grant_count;
`endif

  int tests = 0;
  int fails = 0;
  int ptr   = 0;   // reference round-robin pointer
  int got;

  alu_share_arbiter #(.NUM_REQ(N)) dut (
    .Clock     (Clock),
    .Reset_b   (Reset_b),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_func  (req_func),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef ALU_SHARE_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .grant_count (grant_count)
`endif
  );

  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_alu(input int a, input int b, input int f);
    case (f)
      0:       return 8'(a + b);
      1:       return (a != 0 || b != 0) ? 8'h01 : 8'h00;
      2:       return (a == 15 && b == 15) ? 8'h01 : 8'h00;
      default: return 8'(a * 16 + b);
    endcase
  endfunction

  function automatic int ref_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] f);
    req_valid[i]      = 1'b1;
    req_a[i*4 +: 4]   = a;
    req_b[i*4 +: 4]   = b;
    req_func[i*2 +: 2] = f;
  endtask

  task automatic apply_reset();
    Reset_b   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_func  = '0;
    rsp_ready = 1'b0;
`ifdef ALU_SHARE_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge Clock);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_req_ready", req_ready, 0);
    @(negedge Clock);
    Reset_b = 1'b1;
    ptr = 0;
  endtask

  // One full transaction from an idle cycle with at least one valid request.
  task automatic do_txn(input string tag, input int stall, input bit keep, output int got_id);
    int exp_id;
    int a, b, f;
    logic [7:0] exp_d;
    rsp_ready = (stall == 0);
    #1;
    exp_id = ref_winner(req_valid, ptr);
    if (exp_id < 0) begin
      check({tag, "_no_req"}, req_ready, 0);
      got_id = -1;
      return;
    end
    a = int'(req_a[exp_id*4 +: 4]);
    b = int'(req_b[exp_id*4 +: 4]);
    f = int'(req_func[exp_id*2 +: 2]);
    exp_d = ref_alu(a, b, f);
    check({tag, "_ready"}, req_ready, 32'(1 << exp_id));
    check({tag, "_idle_busy"}, busy, 0);
    step();
    if (!keep) req_valid[exp_id] = 1'b0;
    check({tag, "_exec_valid"}, rsp_valid, 0);
    check({tag, "_exec_busy"}, busy, 1);
    check({tag, "_exec_ready"}, req_ready, 0);
    step();
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_rsp_id"}, rsp_id, exp_id);
    check({tag, "_rsp_data"}, rsp_data, exp_d);
    check({tag, "_rsp_ready"}, req_ready, 0);
    got_id = int'(rsp_id);
    for (int s = 0; s < stall; s++) begin
      step();
      check({tag, "_hold_valid"}, rsp_valid, 1);
      check({tag, "_hold_data"}, rsp_data, exp_d);
      check({tag, "_hold_id"}, rsp_id, exp_id);
      check({tag, "_hold_ready"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    check({tag, "_done_valid"}, rsp_valid, 0);
    check({tag, "_done_busy"}, busy, 0);
    ptr = (exp_id + 1) % N;
  endtask

  initial begin
    Reset_b = 1'b0;
    apply_reset();

    // requester 0 add with carry
    set_req(0, 4'hF, 4'h1, 2'd0);
    do_txn("add_carry", 0, 0, got);
    check("add_carry_id", got, 0);

    // two requesters continuously valid from reset alternate
    apply_reset();
    set_req(0, 4'h3, 4'h4, 2'd0);
    set_req(1, 4'h9, 4'h6, 2'd3);
    for (int i = 0; i < 4; i++) begin
      do_txn($sformatf("alt%0d", i), 0, 1, got);
      check($sformatf("alt%0d_seq", i), got, i % 2);
    end
    req_valid = '0;

    // requester 1 alone: all functions, re-granted back to back
    set_req(1, 4'hF, 4'hF, 2'd2);
    do_txn("and_ones", 0, 1, got);
    set_req(1, 4'h0, 4'h0, 2'd1);
    do_txn("or_zero", 0, 1, got);
    set_req(1, 4'hA, 4'h5, 2'd3);
    do_txn("cat", 0, 0, got);
    check("solo_id", got, 1);

    // backpressure with requester 0 waiting, then immediate regrant
    set_req(0, 4'h7, 4'h8, 2'd0);
    do_txn("stall", 5, 1, got);
    do_txn("after_stall", 0, 0, got);
    check("after_stall_id", got, 0);

    // reset during EXEC aborts; tie afterwards goes to requester 0
    set_req(0, 4'h1, 4'h2, 2'd3);
    set_req(1, 4'h5, 4'h6, 2'd3);
    rsp_ready = 1'b1;
    #1;
    check("abort_pre_ready", req_ready, 32'(1 << ref_winner(req_valid, ptr)));
    step();
    #2;
    Reset_b = 1'b0;
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_req_ready", req_ready, 0);
    check("abort_rsp_data", rsp_data, 0);
    @(posedge Clock);
    #1;
    check("abort_hold_valid", rsp_valid, 0);
    check("abort_hold_busy", busy, 0);
    @(negedge Clock);
    Reset_b = 1'b1;
    ptr = 0;
    do_txn("post_abort", 0, 1, got);
    check("post_abort_id", got, 0);

    // randomized traffic against the reference model
    apply_reset();
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && $urandom_range(0, 3) == 0)
          req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 4'($urandom), 4'($urandom), 2'($urandom));
      end
      if (req_valid == '0)
        set_req($urandom_range(0, N - 1), 4'($urandom), 4'($urandom), 2'($urandom));
      do_txn($sformatf("rnd%0d", it), $urandom_range(0, 3), 0, got);
    end

`ifdef ALU_SHARE_STATS_EN
    apply_reset();
    check("stats_rst", grant_count, 0);
    set_req(0, 4'h2, 4'h3, 2'd0);
    for (int i = 0; i < 300; i++) do_txn("stat", 0, 1, got);
    check("stats_sat0", grant_count[7:0], 8'hFF);
    check("stats_idle1", grant_count[15:8], 8'h00);
    #1;
    check("stats_clr_xfer", req_ready, 1);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    check("stats_clr_wins", grant_count[7:0], 8'h00);
    apply_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
